// File: rtl/xilinx_primitive_pkg.sv
// -----------------------------------------------------------------------------
// xilinx_primitive_pkg
// Shared types and elaboration helpers for the inferred Xilinx-style primitives.
//   fifo_mode_e  : read-side mode of xilinx_fifo_sync (standard / FWFT)
//   fifo_cnt_w   : width of a FIFO occupancy count / wrap-bit pointer
//   is_pow2      : power-of-two test for DEPTH parameter checks
// -----------------------------------------------------------------------------
package xilinx_primitive_pkg;

    typedef enum logic {
        FIFO_STD,
        FIFO_FWFT
    } fifo_mode_e;

    function automatic int unsigned fifo_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int unsigned depth);
        return (depth != 0) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/xilinx_fifo_fwft_stage.sv
// -----------------------------------------------------------------------------
// xilinx_fifo_fwft_stage
// One-entry output register for first-word-fall-through reads. It pulls the
// head word out of the RAM whenever it is empty or being popped, so a pop and
// the presentation of the next word happen on the same edge.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   ram_empty    : registered "RAM holds no word" flag
//   pop          : accepted read of the presented word (only while valid)
//   ram_rdata    : RAM word at the current read pointer
//   ram_rd       : advance the RAM read pointer (word is loaded here)
//   valid_nxt    : next-state valid bit, feeds the parent's EMPTY register
//   dout         : presented word; holds its value while not valid
// -----------------------------------------------------------------------------
module xilinx_fifo_fwft_stage #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SRVAL      = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ram_empty,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  ram_rd,
    output logic                  valid_nxt,
    output logic [DATA_WIDTH-1:0] dout
);

    logic valid;

    always_comb begin
        ram_rd    = !ram_empty && (!valid || pop);
        valid_nxt = ram_rd || (valid && !pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= SRVAL;
        end else begin
            valid <= valid_nxt;
            if (ram_rd) begin
                dout <= ram_rdata;
            end
        end
    end

endmodule

// File: rtl/xilinx_fifo_sync.sv
// -----------------------------------------------------------------------------
// xilinx_fifo_sync
// Single-clock FIFO with inferred storage, exact occupancy count, standard or
// first-word-fall-through read mode, almost flags and error strobes.
// Optional feature macro: XILINX_FIFO_SYNC_PROG_THRESH_EN adds runtime
// AE_THRESH / AF_THRESH ports that replace the almost-flag offsets.
// Ports:
//   CLK, RST     : rising-edge clock, asynchronous active-high reset
//   DI, WREN     : write data / write enable (dropped while FULL)
//   RDEN         : read enable (FWFT: pop of the word shown on DO)
//   DO           : read data, SRVAL after reset
//   EMPTY, FULL  : no readable word / COUNT==DEPTH
//   ALMOSTEMPTY  : COUNT <= empty threshold
//   ALMOSTFULL   : COUNT >= DEPTH - full threshold
//   COUNT        : words held, including the FWFT output word
//   WRERR, RDERR : one-cycle strobes for a rejected WREN / RDEN
//   AE_THRESH, AF_THRESH (macro only) : runtime thresholds
// -----------------------------------------------------------------------------
module xilinx_fifo_sync
    import xilinx_primitive_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH              = 8,
    parameter int unsigned           DEPTH                   = 512,
    parameter int unsigned           ALMOST_EMPTY_OFFSET     = 16,
    parameter int unsigned           ALMOST_FULL_OFFSET      = 16,
    parameter string                 FIRST_WORD_FALL_THROUGH = "FALSE",
    parameter logic [DATA_WIDTH-1:0] SRVAL                   = '0
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [DATA_WIDTH-1:0]         DI,
    input  logic                          WREN,
    input  logic                          RDEN,
    output logic [DATA_WIDTH-1:0]         DO,
    output logic                          EMPTY,
    output logic                          FULL,
    output logic                          ALMOSTEMPTY,
    output logic                          ALMOSTFULL,
    output logic [fifo_cnt_w(DEPTH)-1:0]  COUNT,
    output logic                          WRERR,
    output logic                          RDERR
`ifdef XILINX_FIFO_SYNC_PROG_THRESH_EN
    ,
    input  logic [$clog2(DEPTH)-1:0]      AE_THRESH,
    input  logic [$clog2(DEPTH)-1:0]      AF_THRESH
`endif
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = fifo_cnt_w(DEPTH);
    localparam fifo_mode_e  MODE = (FIRST_WORD_FALL_THROUGH == "TRUE") ? FIFO_FWFT : FIFO_STD;

    // Elaboration-time parameter checks
    if (DATA_WIDTH < 1 || DATA_WIDTH > 1024) begin : g_chk_dw
        $error("xilinx_fifo_sync: DATA_WIDTH must be 1..1024");
    end
    if (DEPTH < 4 || !is_pow2(DEPTH)) begin : g_chk_depth
        $error("xilinx_fifo_sync: DEPTH must be a power of two >= 4");
    end
    if (ALMOST_EMPTY_OFFSET < 1 || ALMOST_EMPTY_OFFSET > DEPTH - 2) begin : g_chk_ae
        $error("xilinx_fifo_sync: ALMOST_EMPTY_OFFSET must be 1..DEPTH-2");
    end
    if (ALMOST_FULL_OFFSET < 1 || ALMOST_FULL_OFFSET > DEPTH - 2) begin : g_chk_af
        $error("xilinx_fifo_sync: ALMOST_FULL_OFFSET must be 1..DEPTH-2");
    end
    if (FIRST_WORD_FALL_THROUGH != "TRUE" && FIRST_WORD_FALL_THROUGH != "FALSE") begin : g_chk_mode
        $error("xilinx_fifo_sync: FIRST_WORD_FALL_THROUGH must be \"TRUE\" or \"FALSE\"");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic [CW-1:0] wptr, rptr, count;
    logic [CW-1:0] wptr_nxt, rptr_nxt, count_nxt;
    logic [CW-1:0] ae_lim, af_lim;
    logic          ram_empty, ram_empty_nxt;
    logic          empty_nxt, ae_nxt;
    logic          wr_acc, rd_acc, ram_rd;

    // Acceptance uses the registered flags; in FWFT mode EMPTY mirrors the
    // output-stage valid bit, so rd_acc is exactly a pop of that word.
    assign wr_acc = WREN && !FULL;
    assign rd_acc = RDEN && !EMPTY;

    assign ram_rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wptr[AW-1:0]] <= DI;
        end
    end

    if (MODE == FIFO_FWFT) begin : g_fwft
        logic valid_nxt;

        xilinx_fifo_fwft_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .SRVAL      (SRVAL)
        ) u_fwft_stage (
            .clk        (CLK),
            .rst        (RST),
            .ram_empty  (ram_empty),
            .pop        (rd_acc),
            .ram_rdata  (ram_rdata),
            .ram_rd     (ram_rd),
            .valid_nxt  (valid_nxt),
            .dout       (DO)
        );

        assign empty_nxt = !valid_nxt;
    end else begin : g_std
        // Same value as rd_acc; EMPTY and ram_empty are equal in this mode.
        assign ram_rd    = RDEN && !ram_empty;
        assign empty_nxt = ram_empty_nxt;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                DO <= SRVAL;
            end else if (ram_rd) begin
                DO <= ram_rdata;
            end
        end
    end

`ifdef XILINX_FIFO_SYNC_PROG_THRESH_EN
    assign ae_lim = CW'(AE_THRESH);
    assign af_lim = CW'(DEPTH) - CW'(AF_THRESH);
`else
    assign ae_lim = CW'(ALMOST_EMPTY_OFFSET);
    assign af_lim = CW'(DEPTH - ALMOST_FULL_OFFSET);
`endif

    always_comb begin
        wptr_nxt      = wptr + CW'(wr_acc);
        rptr_nxt      = rptr + CW'(ram_rd);
        count_nxt     = count + CW'(wr_acc) - CW'(rd_acc);
        ram_empty_nxt = (wptr_nxt == rptr_nxt);
`ifdef XILINX_FIFO_SYNC_PROG_THRESH_EN
        // A zero threshold follows EMPTY exactly, including FWFT latency.
        ae_nxt = (AE_THRESH == '0) ? empty_nxt : (count_nxt <= ae_lim);
`else
        ae_nxt = (count_nxt <= ae_lim);
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            ram_empty   <= 1'b1;
            EMPTY       <= 1'b1;
            FULL        <= 1'b0;
            ALMOSTEMPTY <= 1'b1;
            ALMOSTFULL  <= 1'b0;
            WRERR       <= 1'b0;
            RDERR       <= 1'b0;
        end else begin
            wptr        <= wptr_nxt;
            rptr        <= rptr_nxt;
            count       <= count_nxt;
            ram_empty   <= ram_empty_nxt;
            EMPTY       <= empty_nxt;
            FULL        <= (count_nxt == CW'(DEPTH));
            ALMOSTEMPTY <= ae_nxt;
            ALMOSTFULL  <= (count_nxt >= af_lim);
            WRERR       <= WREN && FULL;
            RDERR       <= RDEN && EMPTY;
        end
    end

    assign COUNT = count;

endmodule

// File: tb/tb_xilinx_fifo_sync.sv
module tb_xilinx_fifo_sync;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AEO   = 4;
    localparam int AFO   = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // standard-mode instance signals
    logic [DW-1:0] s_di, s_do;
    logic          s_we, s_re, s_empty, s_full, s_ae, s_af, s_wrerr, s_rderr;
    logic [4:0]    s_cnt;
    // FWFT-mode instance signals
    logic [DW-1:0] f_di, f_do;
    logic          f_we, f_re, f_empty, f_full, f_ae, f_af, f_wrerr, f_rderr;
    logic [4:0]    f_cnt;

`ifdef XILINX_FIFO_SYNC_PROG_THRESH_EN
    logic [3:0] ae_th = 4'(AEO);
    logic [3:0] af_th = 4'(AFO);
`endif

    xilinx_fifo_sync #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH),
        .ALMOST_EMPTY_OFFSET(AEO), .ALMOST_FULL_OFFSET(AFO),
        .FIRST_WORD_FALL_THROUGH("FALSE"), .SRVAL('0)
    ) u_std (
        .CLK(clk), .RST(rst), .DI(s_di), .WREN(s_we), .RDEN(s_re), .DO(s_do),
        .EMPTY(s_empty), .FULL(s_full), .ALMOSTEMPTY(s_ae), .ALMOSTFULL(s_af),
        .COUNT(s_cnt), .WRERR(s_wrerr), .RDERR(s_rderr)
`ifdef XILINX_FIFO_SYNC_PROG_THRESH_EN
        , .AE_THRESH(ae_th), .AF_THRESH(af_th)
`endif
    );

    xilinx_fifo_sync #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH),
        .ALMOST_EMPTY_OFFSET(AEO), .ALMOST_FULL_OFFSET(AFO),
        .FIRST_WORD_FALL_THROUGH("TRUE"), .SRVAL('0)
    ) u_fwft (
        .CLK(clk), .RST(rst), .DI(f_di), .WREN(f_we), .RDEN(f_re), .DO(f_do),
        .EMPTY(f_empty), .FULL(f_full), .ALMOSTEMPTY(f_ae), .ALMOSTFULL(f_af),
        .COUNT(f_cnt), .WRERR(f_wrerr), .RDERR(f_rderr)
`ifdef XILINX_FIFO_SYNC_PROG_THRESH_EN
        , .AE_THRESH(ae_th), .AF_THRESH(af_th)
`endif
    );

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    logic [DW-1:0] sq[$];
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_d;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pop_s();
        if (sq.size() == 0) return 'x;
        return sq.pop_front();
    endfunction

    function automatic logic [DW-1:0] pop_f();
        if (fq.size() == 0) return 'x;
        return fq.pop_front();
    endfunction

    // flags and count of the standard instance against the model occupancy
    task automatic chk_std(input string tag);
        chk({tag, "_count"}, 32'(s_cnt), 32'(exp_cnt));
        chk({tag, "_empty"}, 32'(s_empty), 32'(exp_cnt == 0));
        chk({tag, "_full"},  32'(s_full),  32'(exp_cnt == DEPTH));
        chk({tag, "_ae"},    32'(s_ae),    32'(exp_cnt <= AEO));
        chk({tag, "_af"},    32'(s_af),    32'(exp_cnt >= DEPTH - AFO));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s_we = 0; s_re = 0; s_di = '0;
        f_we = 0; f_re = 0; f_di = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // reset state
        chk_std("rst");
        chk("rst_wrerr", 32'(s_wrerr), 32'(0));
        chk("rst_rderr", 32'(s_rderr), 32'(0));
        chk("rst_do", 32'(s_do), 32'(0));
        chk("rst_f_empty", 32'(f_empty), 32'(1));
        chk("rst_f_count", 32'(f_cnt), 32'(0));

        // fill standard FIFO 0x01..0x10
        s_we = 1;
        for (int i = 1; i <= DEPTH; i++) begin
            s_di = DW'(i);
            sq.push_back(DW'(i));
            tick();
            exp_cnt = i;
            chk_std("fill");
        end
        // write at FULL is rejected
        s_di = 8'hFF;
        tick();
        chk("wrerr_full", 32'(s_wrerr), 32'(1));
        chk_std("full_hold");
        s_we = 0;
        tick();
        chk("wrerr_clear", 32'(s_wrerr), 32'(0));

        // drain; DO follows each accepted RDEN by one edge
        s_re = 1;
        for (int i = 1; i <= DEPTH; i++) begin
            exp_d = pop_s();
            tick();
            exp_cnt--;
            chk("drain_do", 32'(s_do), 32'(exp_d));
            chk_std("drain");
        end
        tick();
        chk("rderr_empty", 32'(s_rderr), 32'(1));
        chk("rderr_do_hold", 32'(s_do), 32'(8'h10));
        chk_std("rderr");
        s_re = 0;
        tick();
        chk("rderr_clear", 32'(s_rderr), 32'(0));

        // reach COUNT=8, then stream for 100 cycles across pointer wrap
        s_we = 1;
        for (int k = 0; k < 8; k++) begin
            s_di = DW'(8'h20 + k);
            sq.push_back(s_di);
            tick();
            exp_cnt++;
            chk_std("half");
        end
        s_re = 1;
        for (int k = 0; k < 100; k++) begin
            s_di = DW'(8'h30 + k);
            exp_d = pop_s();
            sq.push_back(s_di);
            tick();
            chk("stream_do", 32'(s_do), 32'(exp_d));
            chk("stream_count", 32'(s_cnt), 32'(8));
        end

        // fill to FULL, then WREN+RDEN together
        s_re = 0;
        for (int k = 0; k < 8; k++) begin
            s_di = DW'(8'hC0 + k);
            sq.push_back(s_di);
            tick();
            exp_cnt++;
            chk_std("refill");
        end
        s_re = 1;
        s_di = 8'hEE;
        exp_d = pop_s();
        tick();
        exp_cnt = DEPTH - 1;
        chk("both_full_do", 32'(s_do), 32'(exp_d));
        chk("both_full_wrerr", 32'(s_wrerr), 32'(1));
        chk_std("both_full");
        s_we = 0;

        // drain to COUNT=5
        for (int k = 0; k < 10; k++) begin
            exp_d = pop_s();
            tick();
            exp_cnt--;
            chk("to5_do", 32'(s_do), 32'(exp_d));
            chk_std("to5");
        end
        s_re = 0;
        tick();
        chk_std("at5");

        // reset mid-stream
        rst = 1'b1;
        tick();
        sq.delete();
        exp_cnt = 0;
        chk_std("midrst");
        chk("midrst_do", 32'(s_do), 32'(0));
        chk("midrst_wrerr", 32'(s_wrerr), 32'(0));
        chk("midrst_rderr", 32'(s_rderr), 32'(0));
        rst = 1'b0;
        tick();
        chk_std("post_rst");

        // FWFT: single word, visible on the 2nd edge
        f_we = 1;
        f_di = 8'hA5;
        tick();
        f_we = 0;
        chk("fwft_e1_empty", 32'(f_empty), 32'(1));
        chk("fwft_e1_count", 32'(f_cnt), 32'(1));
        tick();
        chk("fwft_e2_empty", 32'(f_empty), 32'(0));
        chk("fwft_e2_do", 32'(f_do), 32'(8'hA5));
        chk("fwft_e2_count", 32'(f_cnt), 32'(1));
        f_re = 1;
        tick();
        f_re = 0;
        chk("fwft_pop_empty", 32'(f_empty), 32'(1));
        chk("fwft_pop_count", 32'(f_cnt), 32'(0));
        chk("fwft_pop_do_hold", 32'(f_do), 32'(8'hA5));
        f_re = 1;
        tick();
        f_re = 0;
        chk("fwft_rderr", 32'(f_rderr), 32'(1));

        // FWFT: back-to-back pops present the next word on the same edge
        f_we = 1;
        for (int k = 0; k < 3; k++) begin
            f_di = DW'(8'h11 * (k + 1));
            fq.push_back(f_di);
            tick();
        end
        f_we = 0;
        chk("fwft_burst_count", 32'(f_cnt), 32'(3));
        chk("fwft_burst_empty", 32'(f_empty), 32'(0));
        chk("fwft_burst_head", 32'(f_do), 32'(pop_f()));
        f_re = 1;
        for (int k = 2; k >= 1; k--) begin
            tick();
            chk("fwft_burst_do", 32'(f_do), 32'(pop_f()));
            chk("fwft_burst_cnt", 32'(f_cnt), 32'(k));
        end
        tick();
        f_re = 0;
        chk("fwft_burst_end_empty", 32'(f_empty), 32'(1));
        chk("fwft_burst_end_cnt", 32'(f_cnt), 32'(0));
        chk("fwft_burst_end_do", 32'(f_do), 32'(8'h33));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
